// File: rtl/fifo_word_packer.sv
// Packs N_LANES show-ahead fifo entries into one wide word; flush emits a partial word.
// Latency: word_valid rises the cycle after the completing pop or flush. Backpressure: a held output
// word stalls only the final-lane pop; flush with a held output parks in FLUSH_WAIT without popping.
module fifo_word_packer #(
    parameter int W_IN    = 8,
    parameter int N_LANES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [W_IN-1:0]                   fifo_data,
    input  logic                              fifo_empty,
    output logic                              fifo_ready,
    input  logic                              flush,
    output logic [W_IN*N_LANES-1:0]           word_data,
    output logic [$clog2(N_LANES+1)-1:0]      word_bytes,
    output logic                              word_valid,
    input  logic                              word_ready
);

    localparam int CW = $clog2(N_LANES);
    localparam int BW = $clog2(N_LANES+1);

    typedef enum logic {FILL, FLUSH_WAIT} state_t;

    state_t                          state_q, state_d;
    logic [N_LANES-2:0][W_IN-1:0]    lanes_q, lanes_d;
    logic [CW-1:0]                   asm_cnt_q, asm_cnt_d;
    logic [W_IN*N_LANES-1:0]         word_data_q, word_data_d;
    logic [BW-1:0]                   word_bytes_q, word_bytes_d;
    logic                            word_valid_q, word_valid_d;

    logic                            out_free;
    logic                            last_lane;
    logic                            pop;
    logic [BW-1:0]                   fill_n;

    always_comb begin
        out_free  = !word_valid_q || word_ready;
        last_lane = (asm_cnt_q == CW'(N_LANES-1));
        pop       = rst && (state_q == FILL) && !fifo_empty && (!last_lane || out_free);

        state_d      = state_q;
        lanes_d      = lanes_q;
        asm_cnt_d    = asm_cnt_q;
        word_data_d  = word_data_q;
        word_bytes_d = word_bytes_q;
        word_valid_d = word_valid_q;
        fill_n       = BW'(asm_cnt_q);

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (pop && last_lane) begin
                    word_data_d  = {fifo_data, lanes_q};
                    word_bytes_d = BW'(N_LANES);
                    word_valid_d = 1'b1;
                    asm_cnt_d    = '0;
                    lanes_d      = '0;
                end else begin
                    if (pop) begin
                        for (int i = 0; i < N_LANES-1; i++) begin
                            if (CW'(i) == asm_cnt_q) begin
                                lanes_d[i] = fifo_data;
                            end
                        end
                        asm_cnt_d = asm_cnt_q + CW'(1);
                        fill_n    = BW'(asm_cnt_q) + BW'(1);
                    end
                    if (flush && (fill_n != '0)) begin
                        if (out_free) begin
                            // Unfilled lanes are already zero: lanes are cleared on every emit.
                            word_data_d  = {{W_IN{1'b0}}, lanes_d};
                            word_bytes_d = fill_n;
                            word_valid_d = 1'b1;
                            asm_cnt_d    = '0;
                            lanes_d      = '0;
                        end else begin
                            state_d = FLUSH_WAIT;
                        end
                    end
                end
            end
            FLUSH_WAIT: begin
                if (out_free) begin
                    word_data_d  = {{W_IN{1'b0}}, lanes_q};
                    word_bytes_d = BW'(asm_cnt_q);
                    word_valid_d = 1'b1;
                    asm_cnt_d    = '0;
                    lanes_d      = '0;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            lanes_q      <= '0;
            asm_cnt_q    <= '0;
            word_data_q  <= '0;
            word_bytes_q <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lanes_q      <= lanes_d;
            asm_cnt_q    <= asm_cnt_d;
            word_data_q  <= word_data_d;
            word_bytes_q <= word_bytes_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign fifo_ready = pop;
    assign word_data  = word_data_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: directed scenarios with hand-written words, then a random run
// checked against a byte-stream model; a negedge monitor pops expected words on each handshake.
module tb_fifo_word_packer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int BW = $clog2(N+1);

    typedef struct {
        logic [W*N-1:0] data;
        logic [BW-1:0]  bytes;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    fifo_data;
    logic            fifo_empty;
    logic            fifo_ready;
    logic            flush;
    logic [W*N-1:0]  word_data;
    logic [BW-1:0]   word_bytes;
    logic            word_valid;
    logic            word_ready;

    fifo_word_packer #(.W_IN(W), .N_LANES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_ready (fifo_ready),
        .flush      (flush),
        .word_data  (word_data),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fq[$];
    logic [W-1:0] asm_q[$];
    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_miss = 0;
    int           n_pops = 0;
    int           n_words = 0;
    logic         pop_s;
    logic         flush_s;
    logic         auto_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push_exp(input logic [W*N-1:0] d, input int b);
        exp_t e;
        e.data  = d;
        e.bytes = BW'(b);
        exp_q.push_back(e);
    endtask

    task automatic push_asm();
        logic [W*N-1:0] d;
        d = '0;
        for (int i = 0; i < asm_q.size(); i++) d[i*W +: W] = asm_q[i];
        push_exp(d, asm_q.size());
        asm_q.delete();
        n_words++;
    endtask

    task automatic push_bytes(input logic [W-1:0] b);
        fq.push_back(b);
        refresh();
    endtask

    // One clock: sample the pop decision mid-cycle, then advance the fifo model after the edge.
    task automatic cyc();
        logic [W-1:0] b;
        @(negedge clk);
        pop_s   = fifo_ready;
        flush_s = flush;
        if (fifo_ready && fifo_empty) begin
            chk("pop_while_empty", 64'(fifo_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        if (pop_s) begin
            b = fq.pop_front();
            n_pops++;
            if (auto_exp) asm_q.push_back(b);
        end
        if (auto_exp && (asm_q.size() == N || (flush_s && asm_q.size() > 0))) push_asm();
        flush = 1'b0;
        refresh();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    // Monitor: compare on every handshake and check held words stay stable.
    logic           stall_q = 1'b0;
    logic [W*N-1:0] stall_data;
    logic [BW-1:0]  stall_bytes;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(word_valid), 64'd1);
                chk("hold_data", 64'(word_data), 64'(stall_data));
                chk("hold_bytes", 64'(word_bytes), 64'(stall_bytes));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(word_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 64'(word_data), 64'(e.data));
                    chk("word_bytes", 64'(word_bytes), 64'(e.bytes));
                end
            end
            stall_q     = word_valid && !word_ready;
            stall_data  = word_data;
            stall_bytes = word_bytes;
        end
    end

    initial begin
        int p0;
        rst = 1'b0; flush = 1'b0; word_ready = 1'b0;
        refresh();
        push_bytes(8'h99);
        #23;
        chk("rst_valid", 64'(word_valid), 64'd0);
        chk("rst_data", 64'(word_data), 64'd0);
        chk("rst_bytes", 64'(word_bytes), 64'd0);
        chk("rst_fifo_ready", 64'(fifo_ready), 64'd0);
        void'(fq.pop_front());
        refresh();
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic packing and first-word latency
        word_ready = 1'b1;
        push_exp(32'h44332211, 4);
        push_bytes(8'h11); push_bytes(8'h22); push_bytes(8'h33); push_bytes(8'h44);
        p0 = n_pops;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (n_pops - p0 >= 3) chk("basic_valid_timing", 64'(word_valid), 64'(n_pops - p0 == 4));
            if (n_pops - p0 == 4) break;
        end
        chk("basic_pops", 64'(n_pops - p0), 64'd4);
        run(2);

        // Backpressure
        word_ready = 1'b0;
        push_exp(32'h04030201, 4);
        push_exp(32'h08070605, 4);
        for (int i = 1; i <= 8; i++) push_bytes(8'(i));
        run(10);
        chk("bp_valid", 64'(word_valid), 64'd1);
        chk("bp_data", 64'(word_data), 64'h04030201);
        chk("bp_fifo_ready", 64'(fifo_ready), 64'd0);
        chk("bp_fifo_left", 64'(fq.size()), 64'd1);
        word_ready = 1'b1;
        cyc();
        chk("bp_pop_in_handshake", 64'(pop_s), 64'd1);
        chk("bp_next_valid", 64'(word_valid), 64'd1);
        chk("bp_next_data", 64'(word_data), 64'h08070605);
        run(2);

        // Partial flush with empty fifo
        push_exp(32'h0000BBAA, 2);
        push_bytes(8'hAA); push_bytes(8'hBB);
        run(3);
        flush = 1'b1;
        cyc();
        chk("pf_data", 64'(word_data), 64'h0000BBAA);
        chk("pf_bytes", 64'(word_bytes), 64'd2);
        push_exp(32'h04030201, 4);
        for (int i = 1; i <= 4; i++) push_bytes(8'(i));
        run(6);

        // Flush in the same cycle as a pop, then a flush with nothing assembled
        push_exp(32'h00CCBBAA, 3);
        push_bytes(8'hAA); push_bytes(8'hBB);
        run(3);
        push_bytes(8'hCC);
        flush = 1'b1;
        cyc();
        chk("fp_pop", 64'(pop_s), 64'd1);
        chk("fp_data", 64'(word_data), 64'h00CCBBAA);
        chk("fp_bytes", 64'(word_bytes), 64'd3);
        run(2);
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("empty_flush_no_word", 64'(word_valid), 64'd0);
        end

        // Flush while the output is held
        word_ready = 1'b0;
        push_exp(32'h04030201, 4);
        push_exp(32'h00000055, 1);
        push_exp(32'h00000066, 1);
        for (int i = 1; i <= 4; i++) push_bytes(8'(i));
        run(6);
        push_bytes(8'h55);
        run(2);
        flush = 1'b1;
        cyc();
        push_bytes(8'h66);
        chk("fw_no_pop", 64'(fifo_ready), 64'd0);
        cyc();
        chk("fw_no_pop_2", 64'(fifo_ready), 64'd0);
        chk("fw_fifo_left", 64'(fq.size()), 64'd1);
        word_ready = 1'b1;
        cyc();
        chk("fw_data", 64'(word_data), 64'h00000055);
        chk("fw_bytes", 64'(word_bytes), 64'd1);
        run(2);
        flush = 1'b1;
        run(3);

        // Reset mid-word
        push_bytes(8'h77); push_bytes(8'h88);
        run(3);
        rst = 1'b0;
        push_bytes(8'h10); push_bytes(8'h20); push_bytes(8'h30); push_bytes(8'h40);
        #1;
        chk("mr_valid", 64'(word_valid), 64'd0);
        chk("mr_data", 64'(word_data), 64'd0);
        chk("mr_bytes", 64'(word_bytes), 64'd0);
        chk("mr_fifo_ready", 64'(fifo_ready), 64'd0);
        cyc();
        rst = 1'b1;
        push_exp(32'h40302010, 4);
        run(6);
        chk("directed_drained", 64'(exp_q.size()), 64'd0);

        // Random run against the byte-stream model
        auto_exp = 1'b1;
        asm_q.delete();
        for (int c = 0; c < 40000 && n_words < 1000; c++) begin
            if ($urandom_range(0, 9) < 6 && fq.size() < 6) fq.push_back(W'($urandom_range(0, 255)));
            word_ready = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 19) == 0);
            refresh();
            cyc();
        end
        chk("rand_words", 64'(n_words >= 1000), 64'd1);
        word_ready = 1'b1;
        for (int c = 0; c < 200 && fq.size() > 0; c++) cyc();
        flush = 1'b1;
        cyc();
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) cyc();
        chk("rand_fifo_drained", 64'(fq.size()), 64'd0);
        chk("rand_all_words_seen", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the fifo block; drains its show-ahead byte stream (data, empty, pop) and packs N_LANES entries into one wide word.
- Presents each word on a valid/ready output with a lane-count field.
- A flush input emits a partially filled word, so trailing bytes are never stranded.
- Sits between the fifo and the wide-bus sink.

Parameters:
- W_IN, 8, width of one fifo entry (lane width).
- N_LANES, 4, entries per output word; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- fifo_data  input  W_IN  fifo head entry; valid whenever fifo_empty=0.
- fifo_empty  input  1  fifo has no entries.
- fifo_ready  output  1  pop strobe to fifo (drives fifo down_ready); entry consumed at posedge when 1.
- flush  input  1  single-cycle request to emit the partial word.
- word_data  output  W_IN*N_LANES  packed word; lane 0 = first-popped entry, in bits [W_IN-1:0].
- word_bytes  output  $clog2(N_LANES+1)  number of valid lanes in word_data (1..N_LANES).
- word_valid  output  1  word_data/word_bytes valid.
- word_ready  input  1  sink accepts word when word_valid and word_ready are both 1 at posedge.

Behaviour:
- Reset (rst=0, async):
  - word_valid=0, word_data=0, word_bytes=0.
  - Assembly count asm_cnt=0, assembly lanes=0, state=FILL.
  - fifo_ready is forced 0 combinationally while rst=0.
  - A reset mid-word discards the partial assembly; no word is emitted.
- Internal storage:
  - Assembly register: N_LANES-1 lanes plus asm_cnt (0..N_LANES-1).
  - Separate output register, so filling continues while a word waits at the output.
- out_free = !word_valid || word_ready.
- States: FILL, FLUSH_WAIT.
- FILL:
  - fifo_ready = !fifo_empty && (asm_cnt < N_LANES-1 || out_free).
  - Pop with asm_cnt < N_LANES-1: lane[asm_cnt] <= fifo_data, asm_cnt++.
  - Pop with asm_cnt == N_LANES-1: output <= {fifo_data, lanes}, word_bytes=N_LANES, word_valid=1, asm_cnt=0, lanes cleared.
  - Latency: word_valid rises the cycle after the final pop.
  - Throughput: 1 word per N_LANES cycles with word_ready held high.
- Flush (sampled in FILL only; flush in FLUSH_WAIT is ignored, since it is already pending):
  - Let n = asm_cnt + (pop this cycle ? 1 : 0).
  - If n == 0 or n == N_LANES: no extra action. A completing pop already emits the full word, which satisfies the flush.
  - Else if out_free: emit next cycle with word_bytes=n, the same-cycle popped entry in lane asm_cnt, and lanes >= n zero. Then asm_cnt=0.
  - Else: store the popped entry, go to FLUSH_WAIT.
- FLUSH_WAIT:
  - fifo_ready=0.
  - When out_free: emit the partial word as above, clear the assembly, return to FILL.
- Output stability: word_data/word_bytes hold constant while word_valid=1 and word_ready=0.
- Handshake timing:
  - word_valid drops the cycle after a handshake unless a new word loads in the same cycle (back-to-back allowed).
  - word_ready while word_valid=0 has no effect.
- Never pops while fifo_empty=1; a pop that would overflow the output is impossible by construction.

Test Plan (W_IN=8, N_LANES=4):
- Basic packing: fifo supplies 0x11,0x22,0x33,0x44 with word_ready=1 -> word_data=0x44332211, word_bytes=4, word_valid high exactly 1 cycle after the 4th pop.
- Backpressure: entries 0x01..0x08, word_ready=0.
  - Required: word_data=0x04030201 held stable; 3 more pops (asm_cnt=3), then fifo_ready=0 with the fifo non-empty.
  - Raise word_ready: the 8th entry pops in the handshake cycle, and the next word is 0x08070605 with no gap.
- Partial flush: pops 0xAA,0xBB, then flush pulse (fifo empty) -> word_data=0x0000BBAA, word_bytes=2; a subsequent 0x01..0x04 yields 0x04030201.
- Flush with pop: flush in the cycle 0xCC pops after 0xAA,0xBB -> word_data=0x00CCBBAA, word_bytes=3. Flush with asm_cnt=0 and no pop -> word_valid stays 0.
- Flush while output held: word_ready=0 with a word pending, 1 entry 0x55 assembled, flush -> FLUSH_WAIT, fifo_ready=0. On handshake, next word=0x00000055, word_bytes=1.
- Reset mid-word: 2 entries assembled, rst=0 for 1 cycle -> all outputs 0. Then 0x10,0x20,0x30,0x40 -> 0x40302010, word_bytes=4.
- Random scoreboard: 1000 words, random empty/word_ready/flush -> entry order and counts match the model.
